vram_sched: RTL and testbench

Slot scheduler that shares the dual-port VRAM between the CPU-side I/O port and the VGA fetch engine. It sequences the VRAM access window (`VRAM_go`, `io_we`, `io_re`, addresses), arbitrates between the two requesters, and returns captured read data over a level-request / single-cycle-acknowledge handshake. It sits between the VDP port decoder / VGA fetcher and the `vram` instance.

---
 rtl/vram_sched.sv | 166 ++++++++++++++++
 tb/tb_vram_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_sched.sv
// VRAM slot scheduler: arbitrates VGA fetch and CPU I/O into fixed-length VRAM slots.
// Optional macro VRAM_SCHED_STARVE_EN bounds how long an I/O read can wait behind VGA.
module vram_sched_lane (
  input  logic        clk_100,
  input  logic        rst_L,
  input  logic        load,
  input  logic        cap,
  input  logic [13:0] addr_in,
  input  logic [7:0]  rd_in,
  output logic [13:0] addr_q,
  output logic [7:0]  data_q
);
  always_ff @(posedge clk_100) begin
    if (!rst_L) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (load) addr_q <= addr_in;
      if (cap)  data_q <= rd_in;
    end
  end
endmodule

module vram_sched #(
  parameter int SLOT_LEN     = 8,
  parameter int STARVE_LIMIT = 2
) (
  input  logic             clk_100,
  input  logic             rst_L,
  input  logic             io_req,
  input  logic             io_wr,
  input  logic [13:0]      io_addr,
  input  logic [7:0]       io_wdata,
  output logic             io_ack,
  output logic [7:0]       io_rdata,
  input  logic             vga_req,
  input  logic [7:0][13:0] vga_addr_in,
  output logic             vga_done,
  output logic [7:0][7:0]  vga_data,
  output logic [13:0]      vr_io_addr,
  output logic [7:0]       vr_data_in,
  output logic [7:0][13:0] vr_vga_addr,
  output logic             vr_io_we,
  output logic             vr_io_re,
  output logic             vr_go,
  input  logic [7:0]       vr_io_data_out,
  input  logic [7:0][7:0]  vr_vga_data_out
);
  localparam int NUM_LANES = 8;
  localparam int CW        = $clog2(SLOT_LEN);

  if (SLOT_LEN < 8) begin : g_chk_slot
    $error("vram_sched: SLOT_LEN must be at least 8");
  end
  if (STARVE_LIMIT < 1) begin : g_chk_starve
    $error("vram_sched: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {SL_V, SL_VW, SL_W, SL_R} slot_t;

  state_t        state;
  slot_t         slot, gslot;
  logic [CW-1:0] cnt;
  logic          grant, io_v, rd_pend, io_mask, starve_hit, last, cap;

  // An I/O request just acknowledged is ignored for one IDLE cycle so a slow
  // requester cannot be served twice; the VGA fetcher may stream back-to-back.
  assign io_v    = io_req & ~io_mask;
  assign rd_pend = io_v & ~io_wr;
  assign last    = (cnt == CW'(SLOT_LEN - 1));
  assign cap     = (state == RUN) && last && (slot == SL_V || slot == SL_VW);

  always_comb begin
    grant = 1'b1;
    gslot = SL_V;
    if (starve_hit && rd_pend)        gslot = SL_R;
    else if (vga_req && io_v && io_wr) gslot = SL_VW;
    else if (vga_req)                  gslot = SL_V;
    else if (io_v)                     gslot = io_wr ? SL_W : SL_R;
    else                               grant = 1'b0;
  end

`ifdef VRAM_SCHED_STARVE_EN
  localparam int SW = (STARVE_LIMIT >= 4) ? $clog2(STARVE_LIMIT + 1) : 2;
  logic [SW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk_100) begin
    if (!rst_L) starve_cnt <= '0;
    else if (state == IDLE && grant) begin
      if (gslot == SL_R)                     starve_cnt <= '0;
      else if (gslot == SL_V && rd_pend)     starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk_100) begin
    if (!rst_L) begin
      state      <= IDLE;
      slot       <= SL_V;
      cnt        <= '0;
      io_mask    <= 1'b0;
      io_ack     <= 1'b0;
      io_rdata   <= '0;
      vga_done   <= 1'b0;
      vr_io_addr <= '0;
      vr_data_in <= '0;
      vr_io_we   <= 1'b0;
      vr_io_re   <= 1'b0;
      vr_go      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          io_mask <= 1'b0;
          if (grant) begin
            state      <= RUN;
            slot       <= gslot;
            cnt        <= '0;
            vr_go      <= 1'b1;
            vr_io_we   <= (gslot == SL_VW) || (gslot == SL_W);
            vr_io_re   <= (gslot == SL_R);
            vr_io_addr <= io_addr;
            vr_data_in <= io_wdata;
          end
        end
        RUN: begin
          vr_go    <= 1'b0;
          vr_io_we <= 1'b0;
          vr_io_re <= 1'b0;
          if (last) begin
            state    <= DONE;
            vga_done <= (slot == SL_V) || (slot == SL_VW);
            io_ack   <= (slot != SL_V);
            if (slot == SL_R) io_rdata <= vr_io_data_out;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          vga_done <= 1'b0;
          io_ack   <= 1'b0;
          io_mask  <= io_ack;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vram_sched_lane u_lane (
      .clk_100 (clk_100),
      .rst_L   (rst_L),
      .load    ((state == IDLE) && grant),
      .cap     (cap),
      .addr_in (vga_addr_in[i]),
      .rd_in   (vr_vga_data_out[i]),
      .addr_q  (vr_vga_addr[i]),
      .data_q  (vga_data[i])
    );
  end
endmodule

// File: tb/tb_vram_sched.sv
// Scoreboard bench for vram_sched: stimulus pushes expected VRAM strobes/acks, a negedge monitor pops and checks.
module tb_vram_sched;
  logic             clk_100 = 1'b0;
  logic             rst_L;
  logic             io_req, io_wr, io_ack, vga_req, vga_done;
  logic [13:0]      io_addr;
  logic [7:0]       io_wdata, io_rdata;
  logic [7:0][13:0] vga_addr_in, vr_vga_addr;
  logic [7:0][7:0]  vga_data, vr_vga_data_out;
  logic [13:0]      vr_io_addr;
  logic [7:0]       vr_data_in, vr_io_data_out;
  logic             vr_io_we, vr_io_re, vr_go;

  vram_sched #(.SLOT_LEN(8), .STARVE_LIMIT(2)) dut (
    .clk_100(clk_100), .rst_L(rst_L),
    .io_req(io_req), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .vga_req(vga_req), .vga_addr_in(vga_addr_in), .vga_done(vga_done), .vga_data(vga_data),
    .vr_io_addr(vr_io_addr), .vr_data_in(vr_data_in), .vr_vga_addr(vr_vga_addr),
    .vr_io_we(vr_io_we), .vr_io_re(vr_io_re), .vr_go(vr_go),
    .vr_io_data_out(vr_io_data_out), .vr_vga_data_out(vr_vga_data_out)
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  // VRAM model: latches on vr_go; VGA ports return addr[7:0]
  logic [7:0] mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h3FFF] = 8'h3C;
    vr_io_data_out = '0;
    vr_vga_data_out = '0;
  end
  always @(posedge clk_100) begin
    if (vr_go) begin
      if (vr_io_we) mem[vr_io_addr] <= vr_data_in;
      vr_io_data_out <= mem[vr_io_addr];
      for (int i = 0; i < 8; i++) vr_vga_data_out[i] <= vr_vga_addr[i][7:0];
    end
  end

  typedef struct { int cyc; logic we; logic re; logic vg; logic [13:0] addr; logic [7:0] wd; logic [13:0] va7; } go_t;
  typedef struct { int cyc; logic rd; logic [7:0] rdata; } ack_t;
  typedef struct { int cyc; logic [63:0] data; } vga_t;
  go_t  go_q[$];
  ack_t ack_q[$];
  vga_t vga_q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_go(input int c, input logic we, input logic re, input logic vg,
                         input logic [13:0] a, input logic [7:0] d, input logic [13:0] va7);
    go_t e;
    e.cyc = c; e.we = we; e.re = re; e.vg = vg; e.addr = a; e.wd = d; e.va7 = va7;
    go_q.push_back(e);
  endtask
  task automatic push_ack(input int c, input logic rd, input logic [7:0] r);
    ack_t e;
    e.cyc = c; e.rd = rd; e.rdata = r;
    ack_q.push_back(e);
  endtask
  task automatic push_vga(input int c, input logic [63:0] d);
    vga_t e;
    e.cyc = c; e.data = d;
    vga_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk_100) begin
    if (vr_go) begin
      go_t e;
      chk("go_expected", 64'(go_q.size() != 0), 64'd1);
      if (go_q.size() != 0) begin
        e = go_q.pop_front();
        chk("go_cycle", 64'(cyc), 64'(e.cyc));
        chk("go_we", 64'(vr_io_we), 64'(e.we));
        chk("go_re", 64'(vr_io_re), 64'(e.re));
        if (e.we || e.re) chk("go_io_addr", 64'(vr_io_addr), 64'(e.addr));
        if (e.we) chk("go_wdata", 64'(vr_data_in), 64'(e.wd));
        if (e.vg) chk("go_vga_addr7", 64'(vr_vga_addr[7]), 64'(e.va7));
      end
    end
    if (io_ack) begin
      ack_t e;
      chk("ack_expected", 64'(ack_q.size() != 0), 64'd1);
      if (ack_q.size() != 0) begin
        e = ack_q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.rd) chk("io_rdata", 64'(io_rdata), 64'(e.rdata));
      end
    end
    if (vga_done) begin
      vga_t e;
      chk("done_expected", 64'(vga_q.size() != 0), 64'd1);
      if (vga_q.size() != 0) begin
        e = vga_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("vga_data", 64'(vga_data), e.data);
      end
    end
  end

  task automatic set_vga(input logic [13:0] base);
    for (int i = 0; i < 8; i++) vga_addr_in[i] = base + 14'(i);
  endtask

  task automatic wait_io_ack();
    logic got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_100);
      got = io_ack;
    end
    if (!got) chk("io_ack_timeout", 64'd0, 64'd1);
    io_req = 1'b0;
  endtask

  task automatic wait_vga(input int n);
    int seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk_100);
      if (vga_done) seen++;
    end
    if (seen < n) chk("vga_done_timeout", 64'(seen), 64'(n));
    vga_req = 1'b0;
  endtask

  task automatic gap();
    repeat (3) @(negedge clk_100);
  endtask

  int k;
  initial begin
    rst_L = 1'b0; io_req = 1'b0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
    vga_req = 1'b0; vga_addr_in = '0;

    // Reset with both requests high: outputs stay 0, VW slot right after release
    io_req = 1'b1; io_wr = 1'b1; io_addr = 14'h0040; io_wdata = 8'h11;
    vga_req = 1'b1; set_vga(14'h0100);
    repeat (3) begin
      @(negedge clk_100);
      chk("reset_outs_zero", 64'(|{io_ack, io_rdata, vga_done, vga_data, vr_io_addr, vr_data_in,
                                  vr_vga_addr, vr_io_we, vr_io_re, vr_go}), 64'd0);
    end
    k = cyc;
    rst_L = 1'b1;
    push_go(k + 1, 1'b1, 1'b0, 1'b1, 14'h0040, 8'h11, 14'h0107);
    push_ack(k + 9, 1'b0, 8'h00);
    push_vga(k + 9, 64'h0706050403020100);
    fork wait_io_ack(); wait_vga(1); join
    gap();

    // I/O write alone
    k = cyc;
    io_req = 1'b1; io_wr = 1'b1; io_addr = 14'h0123; io_wdata = 8'hA5;
    push_go(k + 1, 1'b1, 1'b0, 1'b0, 14'h0123, 8'hA5, 14'h0);
    push_ack(k + 9, 1'b0, 8'h00);
    wait_io_ack();
    gap();

    // Simultaneous VGA fetch and I/O write share one slot
    k = cyc;
    io_req = 1'b1; io_wr = 1'b1; io_addr = 14'h0200; io_wdata = 8'h5A;
    vga_req = 1'b1; set_vga(14'h0100);
    push_go(k + 1, 1'b1, 1'b0, 1'b1, 14'h0200, 8'h5A, 14'h0107);
    push_ack(k + 9, 1'b0, 8'h00);
    push_vga(k + 9, 64'h0706050403020100);
    fork wait_io_ack(); wait_vga(1); join
    gap();

    // VGA fetch plus I/O read: V slot first, then R
    k = cyc;
    io_req = 1'b1; io_wr = 1'b0; io_addr = 14'h3FFF;
    vga_req = 1'b1; set_vga(14'h0108);
    push_go(k + 1, 1'b0, 1'b0, 1'b1, 14'h3FFF, 8'h00, 14'h010F);
    push_vga(k + 9, 64'h0F0E0D0C0B0A0908);
    push_go(k + 11, 1'b0, 1'b1, 1'b0, 14'h3FFF, 8'h00, 14'h0);
    push_ack(k + 19, 1'b1, 8'h3C);
    fork wait_io_ack(); wait_vga(1); join
    gap();

    // VGA held high with a pending read
    k = cyc;
    io_req = 1'b1; io_wr = 1'b0; io_addr = 14'h3FFF;
    vga_req = 1'b1; set_vga(14'h0100);
    push_go(k + 1, 1'b0, 1'b0, 1'b1, 14'h3FFF, 8'h00, 14'h0107);
    push_vga(k + 9, 64'h0706050403020100);
    push_go(k + 11, 1'b0, 1'b0, 1'b1, 14'h3FFF, 8'h00, 14'h0107);
    push_vga(k + 19, 64'h0706050403020100);
`ifdef VRAM_SCHED_STARVE_EN
    push_go(k + 21, 1'b0, 1'b1, 1'b0, 14'h3FFF, 8'h00, 14'h0);
    push_ack(k + 29, 1'b1, 8'h3C);
    push_go(k + 31, 1'b0, 1'b0, 1'b1, 14'h3FFF, 8'h00, 14'h0107);
    push_vga(k + 39, 64'h0706050403020100);
`else
    push_go(k + 21, 1'b0, 1'b0, 1'b1, 14'h3FFF, 8'h00, 14'h0107);
    push_vga(k + 29, 64'h0706050403020100);
    push_go(k + 31, 1'b0, 1'b1, 1'b0, 14'h3FFF, 8'h00, 14'h0);
    push_ack(k + 39, 1'b1, 8'h3C);
`endif
    fork wait_io_ack(); wait_vga(3); join
    gap();

    // Reset at cnt 4 of an R slot aborts it
    k = cyc;
    io_req = 1'b1; io_wr = 1'b0; io_addr = 14'h3FFF;
    push_go(k + 1, 1'b0, 1'b1, 1'b0, 14'h3FFF, 8'h00, 14'h0);
    while (cyc < k + 5) @(negedge clk_100);
    rst_L = 1'b0;
    io_req = 1'b0;
    @(negedge clk_100);
    rst_L = 1'b1;
    chk("abort_io_rdata", 64'(io_rdata), 64'd0);
    chk("abort_vga_data", 64'(vga_data), 64'd0);
    chk("abort_io_ack", 64'(io_ack), 64'd0);
    chk("abort_state_idle", 64'(dut.state), 64'd0);
    repeat (14) @(negedge clk_100);

    chk("go_q_drained", 64'(go_q.size()), 64'd0);
    chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
    chk("vga_q_drained", 64'(vga_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout act=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end
endmodule
